// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - shared ULA control codes, op encodings and sequencer states
package ula_pkg;

    localparam logic [2:0] ULA_AND = 3'b000;
    localparam logic [2:0] ULA_OR  = 3'b001;
    localparam logic [2:0] ULA_ADD = 3'b010;
    localparam logic [2:0] ULA_SUB = 3'b110;
    localparam logic [2:0] ULA_SLT = 3'b111;

    localparam logic OP_MULTU = 1'b0;
    localparam logic OP_DIVU  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ula_muldiv_seq.sv
// rtl/ula_muldiv_seq.sv - 8x8 multiply / 8/8 divide sequencer driving the shared ULA
module ula_muldiv_seq
    import ula_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       Start,
    input  logic       Op,
    input  logic [7:0] OpA,
    input  logic [7:0] OpB,
    output logic       Busy,
    output logic       Done,
    output logic [7:0] Hi,
    output logic [7:0] Lo,
    output logic       DivZero,
    output logic [7:0] SrcA,
    output logic [7:0] SrcB,
    output logic [2:0] ULAControl,
    input  logic [7:0] ULAResult
);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] b_q, b_d;
    logic [7:0] hi_q, hi_d;
    logic [7:0] lo_q, lo_d;
    logic       op_q, op_d;
    logic       divzero_q, divzero_d;

    logic       carry;
    logic       take;
    logic [7:0] r8;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 3'd0;
            b_q       <= 8'h00;
            hi_q      <= 8'h00;
            lo_q      <= 8'h00;
            op_q      <= OP_MULTU;
            divzero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            b_q       <= b_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            op_q      <= op_d;
            divzero_q <= divzero_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        b_d        = b_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        op_d       = op_q;
        divzero_d  = divzero_q;
        SrcA       = 8'h00;
        SrcB       = 8'h00;
        ULAControl = ULA_AND;
        r8         = {hi_q[6:0], lo_q[7]};
        carry      = 1'b0;
        take       = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) begin
                    state_d = IDLE;
                end
                if (Start) begin
                    b_d       = OpB;
                    op_d      = Op;
                    cnt_d     = 3'd0;
                    divzero_d = 1'b0;
                    if (Op == OP_DIVU && OpB == 8'h00) begin
                        hi_d      = OpA;
                        lo_d      = 8'hFF;
                        divzero_d = 1'b1;
                        state_d   = DONE;
                    end else begin
                        hi_d    = 8'h00;
                        lo_d    = OpA;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q + 3'd1;
                if (op_q == OP_MULTU) begin
                    SrcA       = hi_q;
                    SrcB       = lo_q[0] ? b_q : 8'h00;
                    ULAControl = ULA_ADD;
                    // Wrapped sum is below the addend exactly when the add carried out
                    carry      = (ULAResult < hi_q);
                    hi_d       = {carry, ULAResult[7:1]};
                    lo_d       = {ULAResult[0], lo_q[7:1]};
                end else begin
                    SrcA       = r8;
                    SrcB       = b_q;
                    ULAControl = ULA_SUB;
                    // Shifted-out Hi[7] makes the 9-bit partial remainder >= divisor
                    take       = hi_q[7] | (ULAResult <= r8);
                    hi_d       = take ? ULAResult : r8;
                    lo_d       = {lo_q[6:0], take};
                end
                if (cnt_q == 3'd7) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign Busy    = (state_q == RUN);
    assign Done    = (state_q == DONE);
    assign Hi      = hi_q;
    assign Lo      = lo_q;
    assign DivZero = divzero_q;

endmodule

// File: tb/tb_ula_muldiv_seq.sv
// tb/tb_ula_muldiv_seq.sv - directed self-checking bench with a behavioural ULA
module tb_ula_muldiv_seq;

    logic       clk;
    logic       rst;
    logic       Start;
    logic       Op;
    logic [7:0] OpA;
    logic [7:0] OpB;
    logic       Busy;
    logic       Done;
    logic [7:0] Hi;
    logic [7:0] Lo;
    logic       DivZero;
    logic [7:0] SrcA;
    logic [7:0] SrcB;
    logic [2:0] ULAControl;
    logic [7:0] ULAResult;

    int checks;
    int errors;

    ula_muldiv_seq dut (
        .clk        (clk),
        .rst        (rst),
        .Start      (Start),
        .Op         (Op),
        .OpA        (OpA),
        .OpB        (OpB),
        .Busy       (Busy),
        .Done       (Done),
        .Hi         (Hi),
        .Lo         (Lo),
        .DivZero    (DivZero),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .ULAControl (ULAControl),
        .ULAResult  (ULAResult)
    );

    always_comb begin
        ULAResult = 8'h00;
        case (ULAControl)
            3'b000:  ULAResult = SrcA & SrcB;
            3'b001:  ULAResult = SrcA | SrcB;
            3'b010:  ULAResult = SrcA + SrcB;
            3'b110:  ULAResult = SrcA - SrcB;
            3'b111:  ULAResult = (SrcA < SrcB) ? 8'h01 : 8'h00;
            default: ULAResult = 8'h00;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents Start for one edge (E0) and returns with inputs released just after it
    task automatic issue(input logic op, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        Start = 1'b1;
        Op    = op;
        OpA   = a;
        OpB   = b;
        @(posedge clk);
        #1;
        Start = 1'b0;
    endtask

    // Counts edges after E0 until Done is seen at a falling edge; lat=-1 on timeout
    task automatic wait_done(output int lat, output int busy_cnt, output logic [2:0] run_ctl);
        lat      = -1;
        busy_cnt = 0;
        run_ctl  = 3'b000;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (Busy) begin
                busy_cnt++;
                run_ctl = ULAControl;
            end
            if (Done) begin
                lat = i;
                break;
            end
            @(posedge clk);
        end
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        Start = 1'b0;
        Op    = 1'b0;
        OpA   = 8'h00;
        OpB   = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({Busy, Done, DivZero, Hi, Lo} !== 19'h0) begin
            errors++;
            $display("FAIL reset_state: got Busy=%b Done=%b DivZero=%b Hi=%h Lo=%h, need all 0",
                     Busy, Done, DivZero, Hi, Lo);
        end
        checks++;
        if ({SrcA, SrcB, ULAControl} !== 19'h0) begin
            errors++;
            $display("FAIL reset_drive: got SrcA=%h SrcB=%h ULAControl=%b, need 0", SrcA, SrcB, ULAControl);
        end
    endtask

    task automatic test_multu;
        int lat, bc;
        logic [2:0] ctl;
        issue(1'b0, 8'd200, 8'd200);
        wait_done(lat, bc, ctl);
        checks++;
        if (lat != 9 || bc != 8) begin
            errors++;
            $display("FAIL multu_latency: got latency=%0d busy_cycles=%0d, need 9 and 8", lat, bc);
        end
        checks++;
        if (ctl !== 3'b010) begin
            errors++;
            $display("FAIL multu_ulactl: got %b, need 010", ctl);
        end
        checks++;
        if (Hi !== 8'h9C || Lo !== 8'h40 || DivZero !== 1'b0) begin
            errors++;
            $display("FAIL multu_200x200: got Hi=%h Lo=%h DivZero=%b, need 9C 40 0", Hi, Lo, DivZero);
        end
        checks++;
        if (Busy !== 1'b0 || {SrcA, SrcB, ULAControl} !== 19'h0) begin
            errors++;
            $display("FAIL done_drive: got Busy=%b SrcA=%h SrcB=%h ULAControl=%b, need 0",
                     Busy, SrcA, SrcB, ULAControl);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (Done !== 1'b0 || Hi !== 8'h9C || Lo !== 8'h40) begin
            errors++;
            $display("FAIL multu_hold: got Done=%b Hi=%h Lo=%h, need 0 9C 40", Done, Hi, Lo);
        end
    endtask

    task automatic test_back_to_back;
        int lat, bc;
        logic [2:0] ctl;
        issue(1'b0, 8'd255, 8'd255);
        wait_done(lat, bc, ctl);
        checks++;
        if (lat != 9 || Hi !== 8'hFE || Lo !== 8'h01) begin
            errors++;
            $display("FAIL b2b_first: got latency=%0d Hi=%h Lo=%h, need 9 FE 01", lat, Hi, Lo);
        end
        Start = 1'b1;
        Op    = 1'b1;
        OpA   = 8'd200;
        OpB   = 8'd7;
        @(posedge clk);
        #1;
        Start = 1'b0;
        wait_done(lat, bc, ctl);
        checks++;
        if (lat != 9 || bc != 8 || ctl !== 3'b110) begin
            errors++;
            $display("FAIL b2b_second_timing: got latency=%0d busy=%0d ctl=%b, need 9 8 110", lat, bc, ctl);
        end
        checks++;
        if (Lo !== 8'h1C || Hi !== 8'h04 || DivZero !== 1'b0) begin
            errors++;
            $display("FAIL divu_200_7: got Lo=%h Hi=%h DivZero=%b, need 1C 04 0", Lo, Hi, DivZero);
        end
    endtask

    task automatic test_divu;
        int lat, bc;
        logic [2:0] ctl;
        issue(1'b1, 8'd255, 8'd1);
        wait_done(lat, bc, ctl);
        checks++;
        if (lat != 9 || Lo !== 8'hFF || Hi !== 8'h00) begin
            errors++;
            $display("FAIL divu_255_1: got latency=%0d Lo=%h Hi=%h, need 9 FF 00", lat, Lo, Hi);
        end
        issue(1'b1, 8'd5, 8'd200);
        wait_done(lat, bc, ctl);
        checks++;
        if (lat != 9 || Lo !== 8'h00 || Hi !== 8'h05) begin
            errors++;
            $display("FAIL divu_5_200: got latency=%0d Lo=%h Hi=%h, need 9 00 05", lat, Lo, Hi);
        end
        issue(1'b1, 8'd250, 8'd130);
        wait_done(lat, bc, ctl);
        checks++;
        if (Lo !== 8'h01 || Hi !== 8'h78) begin
            errors++;
            $display("FAIL divu_250_130: got Lo=%h Hi=%h, need 01 78", Lo, Hi);
        end
    endtask

    task automatic test_divzero;
        int lat, bc;
        logic [2:0] ctl;
        issue(1'b1, 8'h5A, 8'h00);
        wait_done(lat, bc, ctl);
        checks++;
        if (lat != 1 || bc != 0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL divzero_timing: got latency=%0d busy_cycles=%0d, need 1 0", lat, bc);
        end
        checks++;
        if (Hi !== 8'h5A || Lo !== 8'hFF || DivZero !== 1'b1) begin
            errors++;
            $display("FAIL divzero_result: got Hi=%h Lo=%h DivZero=%b, need 5A FF 1", Hi, Lo, DivZero);
        end
        issue(1'b0, 8'd2, 8'd2);
        @(negedge clk);
        checks++;
        if (DivZero !== 1'b0) begin
            errors++;
            $display("FAIL divzero_clear: got DivZero=%b, need 0", DivZero);
        end
        wait_done(lat, bc, ctl);
    endtask

    task automatic test_start_ignored;
        int done_cnt;
        int first;
        issue(1'b0, 8'd200, 8'd200);
        done_cnt = 0;
        first    = -1;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i == 3) begin
                Start = 1'b1;
                Op    = 1'b1;
                OpA   = 8'd17;
                OpB   = 8'd3;
            end
            if (i == 4) Start = 1'b0;
            if (Done) begin
                done_cnt++;
                if (first < 0) first = i;
            end
            if (i == 9) begin
                checks++;
                if (Hi !== 8'h9C || Lo !== 8'h40) begin
                    errors++;
                    $display("FAIL ignore_result: got Hi=%h Lo=%h, need 9C 40", Hi, Lo);
                end
            end
            @(posedge clk);
        end
        checks++;
        if (done_cnt != 1 || first != 9) begin
            errors++;
            $display("FAIL ignore_done_pulses: got count=%0d at=%0d, need 1 at 9", done_cnt, first);
        end
    endtask

    task automatic test_reset_mid_run;
        int lat, bc;
        logic [2:0] ctl;
        issue(1'b0, 8'd255, 8'd255);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (Busy !== 1'b1 || Hi === 8'h00) begin
            errors++;
            $display("FAIL midrun_precondition: got Busy=%b Hi=%h, need 1 and nonzero", Busy, Hi);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({Busy, Done, DivZero, Hi, Lo, SrcA, SrcB, ULAControl} !== 38'h0) begin
            errors++;
            $display("FAIL midrun_reset: got Busy=%b Done=%b Hi=%h Lo=%h SrcA=%h SrcB=%h ctl=%b, need 0",
                     Busy, Done, Hi, Lo, SrcA, SrcB, ULAControl);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue(1'b0, 8'd3, 8'd4);
        wait_done(lat, bc, ctl);
        checks++;
        if (lat != 9 || Lo !== 8'h0C || Hi !== 8'h00) begin
            errors++;
            $display("FAIL post_reset_3x4: got latency=%0d Lo=%h Hi=%h, need 9 0C 00", lat, Lo, Hi);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_multu();
        test_back_to_back();
        test_divu();
        test_divzero();
        test_start_ignored();
        test_reset_mid_run();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
